// File: rtl/debounce_multi.sv
// ---------------------------------------------------------------------------
// debounce_multi
//
// Multi-channel pushbutton/switch debouncer. Every channel is independent:
// an input synchroniser, a symmetric stable-time filter (same time for press
// and release), a debounced level and registered one-cycle event pulses.
//
// Optional feature (compile-time macro): AUTO_REPEAT_EN
//   When defined, each channel gets a small IDLE/HELD/REPEAT state machine
//   that emits extra press pulses while the button stays held: the first
//   after REPEAT_DELAY_MS, then every REPEAT_RATE_MS. When undefined no
//   repeat hardware exists and the REPEAT_* parameters have no effect.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   rst            asynchronous, active-low reset
//   button         raw asynchronous button inputs, one bit per channel
//   level          debounced, active-high button state
//   press          one-cycle pulse when level rises (and on each repeat)
//   release_pulse  one-cycle pulse when level falls ("release" alone is a
//                  reserved word in SystemVerilog, hence the longer name)
// ---------------------------------------------------------------------------
module debounce_multi #(
   parameter int CHANNELS        = 4,
   parameter int CLK_FREQ        = 125_000_000,
   parameter int STABLE_MS       = 10,
   parameter int SYNC_STAGES     = 2,
   parameter int ACTIVE_LOW      = 0,
   parameter int REPEAT_DELAY_MS = 500,
   parameter int REPEAT_RATE_MS  = 100
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] button,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] press,
   output logic [CHANNELS-1:0] release_pulse
);

   // Number of consecutive differing samples needed before the level flips.
   localparam int MAX_DELAY = CLK_FREQ / 1000 * STABLE_MS;
   localparam int CNT_W     = $clog2(MAX_DELAY + 1);

   if (MAX_DELAY < 2) begin : g_bad_delay
      $error("debounce_multi: stable time must be at least 2 clock cycles");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("debounce_multi: SYNC_STAGES must be in 2..4");
   end
   if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_chan
      $error("debounce_multi: CHANNELS must be in 1..32");
   end

`ifdef AUTO_REPEAT_EN
   // 64-bit intermediate: ms * Hz overflows 32 bits at realistic clocks.
   localparam longint RPT_DELAY_L = longint'(REPEAT_DELAY_MS) * longint'(CLK_FREQ) / 64'sd1000;
   localparam longint RPT_RATE_L  = longint'(REPEAT_RATE_MS) * longint'(CLK_FREQ) / 64'sd1000;
   localparam int     RPT_DELAY   = int'(RPT_DELAY_L);
   localparam int     RPT_RATE    = int'(RPT_RATE_L);
   localparam int     RPT_MAX     = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
   localparam int     RPT_W       = $clog2(RPT_MAX + 1);

   if (RPT_DELAY < 2 || RPT_RATE < 2) begin : g_bad_rpt
      $error("debounce_multi: repeat periods must be at least 2 clock cycles");
   end

   typedef enum logic [1:0] {IDLE, HELD, REPEAT} rpt_state_e;
`else
   // Repeat timing is unused in this build; only reject nonsense values so
   // a configuration stays valid when the feature is switched on later.
   if (REPEAT_DELAY_MS < 0 || REPEAT_RATE_MS < 0) begin : g_bad_rpt
      $error("debounce_multi: repeat times must not be negative");
   end
`endif

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [CNT_W-1:0]       cnt_q;
      logic                   lvl_q;
      logic                   press_q;
      logic                   rel_q;
      logic                   din;
      logic                   s;
      logic                   expired;
      logic                   rise;
      logic                   fall;
      logic                   fire;

      assign din     = (ACTIVE_LOW != 0) ? ~button[ch] : button[ch];
      assign s       = sync_q[SYNC_STAGES-1];
      assign expired = (s != lvl_q) && (cnt_q == CNT_W'(MAX_DELAY - 1));
      assign rise    = expired & ~lvl_q;
      assign fall    = expired & lvl_q;

      // Input synchroniser. Polarity is normalised before the first stage so
      // that reset (all zeros) always means "not pressed".
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sync_q <= '0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         end
      end

      // Stable-time filter. The counter only runs while the synchronised
      // input disagrees with the current level; any agreeing sample restarts
      // it. It tops out at MAX_DELAY-1, where the level flips, so it never
      // wraps.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
         end else if (s == lvl_q) begin
            cnt_q <= '0;
         end else if (expired) begin
            cnt_q <= '0;
            lvl_q <= ~lvl_q;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end

      // Registered event pulses, aligned with the level change. A falling
      // edge suppresses any repeat press in the same cycle.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            press_q <= rise | fire;
            rel_q   <= fall;
         end
      end

`ifdef AUTO_REPEAT_EN
      rpt_state_e       state_q;
      rpt_state_e       state_d;
      logic [RPT_W-1:0] rcnt_q;
      logic [RPT_W-1:0] rcnt_d;

      // Repeat state register and its cycle counter.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
         end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
         end
      end

      // Next-state logic: HELD times the initial delay, REPEAT times the
      // repeat period; a level fall returns to IDLE from either.
      always_comb begin
         state_d = state_q;
         rcnt_d  = rcnt_q;
         case (state_q)
            IDLE: begin
               rcnt_d = '0;
               if (rise) state_d = HELD;
            end
            HELD: begin
               if (fall) begin
                  state_d = IDLE;
                  rcnt_d  = '0;
               end else if (rcnt_q == RPT_W'(RPT_DELAY - 1)) begin
                  state_d = REPEAT;
                  rcnt_d  = '0;
               end else begin
                  rcnt_d = rcnt_q + RPT_W'(1);
               end
            end
            REPEAT: begin
               if (fall) begin
                  state_d = IDLE;
                  rcnt_d  = '0;
               end else if (rcnt_q == RPT_W'(RPT_RATE - 1)) begin
                  rcnt_d = '0;
               end else begin
                  rcnt_d = rcnt_q + RPT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               rcnt_d  = '0;
            end
         endcase
      end

      // Output logic: a repeat press whenever the running period completes,
      // unless the button is being released in that same cycle.
      always_comb begin
         fire = 1'b0;
         if (!fall) begin
            if (state_q == HELD && rcnt_q == RPT_W'(RPT_DELAY - 1)) fire = 1'b1;
            if (state_q == REPEAT && rcnt_q == RPT_W'(RPT_RATE - 1)) fire = 1'b1;
         end
      end
`else
      assign fire = 1'b0;
`endif

      assign level[ch]         = lvl_q;
      assign press[ch]         = press_q;
      assign release_pulse[ch] = rel_q;
   end

endmodule

// File: tb/tb_debounce_multi.sv
// ---------------------------------------------------------------------------
// tb_debounce_multi
//
// Drives two debounce_multi instances (active-high and active-low buttons)
// with directed sequences and random button activity, and compares every
// output each cycle with a window-based reference model. Build with
// AUTO_REPEAT_EN defined to exercise the auto-repeat feature as well.
// ---------------------------------------------------------------------------
module tb_debounce_multi;

   localparam int NCH   = 4;
   localparam int SYNC  = 2;
   localparam int MAXD  = 10;
   localparam int RPT_D = 20;
   localparam int RPT_R = 5;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [NCH-1:0] btnA = '0;
   logic [NCH-1:0] btnB = '1;
   logic [NCH-1:0] lvlA, prsA, relA;
   logic [NCH-1:0] lvlB, prsB, relB;

   int checks = 0;
   int errors = 0;
   int edgeNo = 0;

   // Reference model state, index 0 = active-high DUT, 1 = active-low DUT.
   logic [NCH-1:0] mPipe[2][SYNC];
   logic [NCH-1:0] mHist[2][MAXD];
   int             mSince[2][NCH];
   int             mRiseAt[2][NCH];
   logic [NCH-1:0] mLvl[2];
   logic [NCH-1:0] mPrs[2];
   logic [NCH-1:0] mRel[2];

   debounce_multi #(
      .CHANNELS(NCH), .CLK_FREQ(1000), .STABLE_MS(10), .SYNC_STAGES(SYNC),
      .ACTIVE_LOW(0), .REPEAT_DELAY_MS(20), .REPEAT_RATE_MS(5)
   ) dut (
      .clk(clk), .rst(rst), .button(btnA),
      .level(lvlA), .press(prsA), .release_pulse(relA)
   );

   debounce_multi #(
      .CHANNELS(NCH), .CLK_FREQ(1000), .STABLE_MS(10), .SYNC_STAGES(SYNC),
      .ACTIVE_LOW(1), .REPEAT_DELAY_MS(20), .REPEAT_RATE_MS(5)
   ) dut_al (
      .clk(clk), .rst(rst), .button(btnB),
      .level(lvlB), .press(prsB), .release_pulse(relB)
   );

   // 10-unit clock period.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h at edge %0d", tag, got, exp, edgeNo);
      end
   endtask

   // Model reset: synchroniser empty, no history, everything released.
   task automatic modelResetAll();
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < SYNC; j++) mPipe[k][j] = '0;
         for (int j = 0; j < MAXD; j++) mHist[k][j] = '0;
         for (int ch = 0; ch < NCH; ch++) begin
            mSince[k][ch]  = 0;
            mRiseAt[k][ch] = 0;
         end
         mLvl[k] = '0;
         mPrs[k] = '0;
         mRel[k] = '0;
      end
   endtask

   // One rising edge of the model: the level flips once the last MAXD
   // synchronised samples since the previous flip all disagree with it.
   task automatic modelEdge(input int k, input logic [NCH-1:0] raw);
      logic [NCH-1:0] s;
      logic           allDiff;
      s = mPipe[k][SYNC-1];
      for (int j = SYNC - 1; j > 0; j--) mPipe[k][j] = mPipe[k][j-1];
      mPipe[k][0] = (k == 1) ? ~raw : raw;
      for (int j = MAXD - 1; j > 0; j--) mHist[k][j] = mHist[k][j-1];
      mHist[k][0] = s;
      mPrs[k] = '0;
      mRel[k] = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         if (mSince[k][ch] < MAXD) mSince[k][ch]++;
         allDiff = (mSince[k][ch] >= MAXD);
         for (int j = 0; j < MAXD; j++) begin
            if (mHist[k][j][ch] == mLvl[k][ch]) allDiff = 1'b0;
         end
         if (allDiff) begin
            if (!mLvl[k][ch]) begin
               mPrs[k][ch]    = 1'b1;
               mRiseAt[k][ch] = edgeNo;
            end else begin
               mRel[k][ch] = 1'b1;
            end
            mLvl[k][ch]   = ~mLvl[k][ch];
            mSince[k][ch] = 0;
         end
`ifdef AUTO_REPEAT_EN
         else if (mLvl[k][ch]) begin
            int d;
            d = edgeNo - mRiseAt[k][ch];
            if (d == RPT_D || (d > RPT_D && (d - RPT_D) % RPT_R == 0)) mPrs[k][ch] = 1'b1;
         end
`endif
      end
   endtask

   // Advance one clock, update the model and compare all outputs 1 unit later.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         modelEdge(0, btnA);
         modelEdge(1, btnB);
         edgeNo++;
      end else begin
         modelResetAll();
      end
      #1;
      checkOutput("levelA", 32'(lvlA), 32'(mLvl[0]));
      checkOutput("pressA", 32'(prsA), 32'(mPrs[0]));
      checkOutput("releaseA", 32'(relA), 32'(mRel[0]));
      checkOutput("levelB", 32'(lvlB), 32'(mLvl[1]));
      checkOutput("pressB", 32'(prsB), 32'(mPrs[1]));
      checkOutput("releaseB", 32'(relB), 32'(mRel[1]));
   endtask

   // Hold both button buses at the given values for n clock edges.
   task automatic applyStimulus(input logic [NCH-1:0] a, input logic [NCH-1:0] b, input int n);
      btnA = a;
      btnB = b;
      repeat (n) tick();
   endtask

   int holdA[NCH];
   int holdB[NCH];
   int presses;
   int expRepeats;

   initial begin
      modelResetAll();
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_levelA", 32'(lvlA), 32'h0);
      checkOutput("rst_levelB", 32'(lvlB), 32'h0);
      checkOutput("rst_pressA", 32'(prsA), 32'h0);
      applyStimulus(4'h0, 4'hF, 3);
      rst = 1'b1;
      applyStimulus(4'h0, 4'hF, 3);

      $display("[TB] press on channel 0");
      applyStimulus(4'b0001, 4'hF, 11);
      checkOutput("t1_level_early", 32'(lvlA[0]), 32'h0);
      tick();
      checkOutput("t1_level", 32'(lvlA), 32'h1);
      checkOutput("t1_press", 32'(prsA[0]), 32'h1);
      tick();
      checkOutput("t1_press_once", 32'(prsA[0]), 32'h0);
      applyStimulus(4'b0001, 4'hF, 4);

      $display("[TB] interrupted press on channel 1");
      applyStimulus(4'b0011, 4'hF, 9);
      applyStimulus(4'b0001, 4'hF, 1);
      applyStimulus(4'b0011, 4'hF, 11);
      checkOutput("t2_level_early", 32'(lvlA[1]), 32'h0);
      tick();
      checkOutput("t2_level", 32'(lvlA[1]), 32'h1);
      checkOutput("t2_press", 32'(prsA[1]), 32'h1);
      applyStimulus(4'b0011, 4'hF, 3);

      $display("[TB] glitch then release on channel 0");
      applyStimulus(4'b0010, 4'hF, 5);
      applyStimulus(4'b0011, 4'hF, 20);
      checkOutput("t3_glitch_level", 32'(lvlA[0]), 32'h1);
      applyStimulus(4'b0010, 4'hF, 11);
      checkOutput("t3_level_early", 32'(lvlA[0]), 32'h1);
      tick();
      checkOutput("t3_level", 32'(lvlA[0]), 32'h0);
      checkOutput("t3_release", 32'(relA[0]), 32'h1);
      applyStimulus(4'b0010, 4'hF, 5);

      $display("[TB] active-low channel 2 and reset while held");
      applyStimulus(4'b0010, 4'b1011, 11);
      checkOutput("t4_level_early", 32'(lvlB), 32'h0);
      tick();
      checkOutput("t4_level", 32'(lvlB), 32'h4);
      checkOutput("t4_press", 32'(prsB), 32'h4);
      applyStimulus(4'b0010, 4'b1011, 5);
      rst = 1'b0;
      modelResetAll();
      #1;
      checkOutput("t4_rst_levelB", 32'(lvlB), 32'h0);
      checkOutput("t4_rst_levelA", 32'(lvlA), 32'h0);
      applyStimulus(4'b0010, 4'b1011, 3);
      rst = 1'b1;
      applyStimulus(4'b0010, 4'b1011, 11);
      checkOutput("t4_relevel_early", 32'(lvlB), 32'h0);
      tick();
      checkOutput("t4_relevel", 32'(lvlB), 32'h4);
      checkOutput("t4_relevelA", 32'(lvlA), 32'h2);

      $display("[TB] simultaneous channels 0 and 3");
      applyStimulus(4'b0000, 4'hF, 15);
      applyStimulus(4'b1001, 4'hF, 11);
      tick();
      checkOutput("t5_press", 32'(prsA), 32'h9);
      checkOutput("t5_level", 32'(lvlA), 32'h9);

      $display("[TB] long hold on channel 0");
      presses = 0;
      for (int i = 0; i < 49; i++) begin
         tick();
         if (prsA[0]) presses++;
      end
`ifdef AUTO_REPEAT_EN
      expRepeats = 6;
`else
      expRepeats = 0;
`endif
      checkOutput("t6_repeats", 32'(presses), 32'(expRepeats));
      applyStimulus(4'b0000, 4'hF, 15);
      checkOutput("t6_released", 32'(lvlA), 32'h0);

      $display("[TB] random activity");
      for (int ch = 0; ch < NCH; ch++) begin
         holdA[ch] = $urandom_range(1, 40);
         holdB[ch] = $urandom_range(1, 40);
      end
      for (int cyc = 0; cyc < 1200; cyc++) begin
         if (cyc == 600) begin
            rst = 1'b0;
            modelResetAll();
         end
         if (cyc == 603) rst = 1'b1;
         for (int ch = 0; ch < NCH; ch++) begin
            holdA[ch]--;
            holdB[ch]--;
            if (holdA[ch] <= 0) begin
               btnA[ch]  = ~btnA[ch];
               holdA[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : $urandom_range(10, 40);
            end
            if (holdB[ch] <= 0) begin
               btnB[ch]  = ~btnB[ch];
               holdB[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : $urandom_range(10, 40);
            end
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
